f_pc_sched: RTL and testbench

//  Fetch-stage PC scheduler for the 5-stage MIPS pipeline. Owns the F-stage PC register.

---
 rtl/f_pc_sched.sv | 123 ++++++++++++
 tb/tb_f_pc_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/f_pc_sched.sv
// f_pc_sched: fetch-stage PC scheduler; owns F_PC and chooses PC+4, a D-stage redirect, or hold.
// Latency: a redirect sampled in cycle N is on F_PC in N+1; PC4 and fetch_exc are combinational.
// Backpressure: stall holds F_PC; a redirect seen while stalled is latched (pend) and applied on release.
//
// Optional feature: define PC_CHECK_EN to enable fetch-address range/alignment checking
// (fetch_exc plus forced redirect to EXC_PC). Undefined: fetch_exc tied 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   stall               hold F_PC this cycle
//   redir_valid/target  D-stage branch/jal/jr redirect
//   F_PC, PC4           registered fetch address and its +4 successor
//   pend                redirect latched and waiting for stall release
//   cnt_cycle/stall/redir  debug performance counters (wrap at 2^CNT_W)
//   fetch_exc           F_PC illegal this cycle
module f_pc_sched #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6FFC,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redir_valid,
  input  logic [31:0]      redir_target,
  output logic [31:0]      F_PC,
  output logic [31:0]      PC4,
  output logic             pend,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_redir,
  output logic             fetch_exc
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        redir_inc;
  logic        exc_w;

`ifdef PC_CHECK_EN
  assign exc_w = (pc_q[1:0] != 2'b00) | (pc_q < PC_LO) | (pc_q > PC_HI);
`else
  logic unused_cfg;
  assign exc_w      = 1'b0;
  assign unused_cfg = ^{PC_LO, PC_HI, EXC_PC};
`endif

  // State register, PC, latched target and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      tgt_q     <= 32'h0;
      cnt_cycle <= '0;
      cnt_stall <= '0;
      cnt_redir <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      cnt_cycle <= cnt_cycle + CNT_W'(1);
      if (stall)     cnt_stall <= cnt_stall + CNT_W'(1);
      if (redir_inc) cnt_redir <= cnt_redir + CNT_W'(1);
    end
  end

  // Next-state / next-PC selection.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    redir_inc = 1'b0;
    if (exc_w && !stall) begin
      // Exception vector beats every redirect and is not counted as one.
      pc_d    = EXC_PC;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (stall) begin
            if (redir_valid) begin
              tgt_d   = redir_target;
              state_d = PEND;
            end
          end else if (redir_valid) begin
            pc_d      = redir_target;
            redir_inc = 1'b1;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
        PEND: begin
          if (stall) begin
            // A younger redirect replaces the one already waiting.
            if (redir_valid) tgt_d = redir_target;
          end else begin
            pc_d      = redir_valid ? redir_target : tgt_q;
            redir_inc = 1'b1;
            state_d   = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    F_PC      = pc_q;
    PC4       = pc_q + 32'd4;
    pend      = (state_q == PEND);
    fetch_exc = exc_w;
  end

endmodule

// File: tb/tb_f_pc_sched.sv
module tb_f_pc_sched;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic [31:0] F_PC;
  logic [31:0] PC4;
  logic        pend;
  logic [31:0] cnt_cycle;
  logic [31:0] cnt_stall;
  logic [31:0] cnt_redir;
  logic        fetch_exc;

  int n_chk  = 0;
  int n_pass = 0;

  f_pc_sched dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .F_PC         (F_PC),
    .PC4          (PC4),
    .pend         (pend),
    .cnt_cycle    (cnt_cycle),
    .cnt_stall    (cnt_stall),
    .cnt_redir    (cnt_redir),
    .fetch_exc    (fetch_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pnd;
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] rdr;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc, m_tgt, m_cyc, m_stl, m_rdr;
  logic        m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic m_exc(input logic [31:0] pc);
`ifdef PC_CHECK_EN
    logic [31:0] p;
    p = pc;
    return (p[1:0] != 2'b00) || (p < 32'h3000) || (p > 32'h6FFC);
`else
    return (pc === 32'hx);
`endif
  endfunction

  // Drive one cycle, advance the model, then compare the DUT after the edge.
  task automatic cycle(input logic rst, input logic st, input logic rv, input logic [31:0] tg);
    exp_t e;
    logic x;
    reset        = rst;
    stall        = st;
    redir_valid  = rv;
    redir_target = tg;
    if (rst) begin
      m_pc = 32'h3000; m_pend = 1'b0; m_tgt = 32'h0;
      m_cyc = 0; m_stl = 0; m_rdr = 0;
    end else begin
      x = m_exc(m_pc);
      m_cyc = m_cyc + 1;
      if (st) m_stl = m_stl + 1;
      if (x && !st) begin
        m_pc = 32'h4180; m_pend = 1'b0;
      end else if (st) begin
        if (rv) begin m_tgt = tg; m_pend = 1'b1; end
      end else if (rv) begin
        m_pc = tg; m_pend = 1'b0; m_rdr = m_rdr + 1;
      end else if (m_pend) begin
        m_pc = m_tgt; m_pend = 1'b0; m_rdr = m_rdr + 1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    e.pc = m_pc; e.pnd = m_pend; e.cyc = m_cyc; e.stl = m_stl; e.rdr = m_rdr;
    e.exc = m_exc(m_pc);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("sb_pc",    F_PC,      e.pc);
      chk("sb_pc4",   PC4,       e.pc + 32'd4);
      chk("sb_pend",  {31'd0, pend}, {31'd0, e.pnd});
      chk("sb_cyc",   cnt_cycle, e.cyc);
      chk("sb_stl",   cnt_stall, e.stl);
      chk("sb_rdr",   cnt_redir, e.rdr);
      chk("sb_exc",   {31'd0, fetch_exc}, {31'd0, e.exc});
    end
  endtask

  initial begin
    logic [31:0] base_rdr;
    reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = 32'h0;

    // Reset for two cycles
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("rst_pc",   F_PC, 32'h3000);
    chk("rst_pc4",  PC4, 32'h3004);
    chk("rst_pend", {31'd0, pend}, 32'd0);
    chk("rst_cnt",  cnt_cycle | cnt_stall | cnt_redir, 32'd0);
    chk("rst_exc",  {31'd0, fetch_exc}, 32'd0);

    // Sequential fetch
    cycle(0, 0, 0, 0); chk("seq_3004", F_PC, 32'h3004);
    cycle(0, 0, 0, 0); chk("seq_3008", F_PC, 32'h3008);
    cycle(0, 0, 0, 0); chk("seq_300c", F_PC, 32'h300C);
    chk("seq_cyc3", cnt_cycle, 32'd3);
    cycle(0, 0, 0, 0); chk("seq_3010", F_PC, 32'h3010);

    // Unstalled redirect
    cycle(0, 0, 1, 32'h3100);
    chk("redir_pc", F_PC, 32'h3100);
    chk("redir_cnt", cnt_redir, 32'd1);
    cycle(0, 0, 1, 32'h3010);

    // Redirect during stall is latched and applied on release
    cycle(0, 1, 1, 32'h3200);
    chk("stl_hold1", F_PC, 32'h3010);
    chk("stl_pend1", {31'd0, pend}, 32'd1);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    chk("stl_hold3", F_PC, 32'h3010);
    chk("stl_pend3", {31'd0, pend}, 32'd1);
    cycle(0, 0, 0, 0);
    chk("stl_apply", F_PC, 32'h3200);
    chk("stl_pend0", {31'd0, pend}, 32'd0);
    chk("stl_cnt3",  cnt_stall, 32'd3);
    chk("stl_rdr",   cnt_redir, 32'd3);

    // Live redirect beats latched one on release
    cycle(0, 1, 1, 32'h3200);
    base_rdr = cnt_redir;
    cycle(0, 0, 1, 32'h3300);
    chk("live_pc",   F_PC, 32'h3300);
    chk("live_pend", {31'd0, pend}, 32'd0);
    chk("live_rdr",  cnt_redir, base_rdr + 32'd1);

    // Reset while pending drops the latched target
    cycle(0, 1, 1, 32'h3400);
    chk("rp_pend", {31'd0, pend}, 32'd1);
    cycle(1, 0, 0, 0);
    chk("rp_pc",   F_PC, 32'h3000);
    chk("rp_pend0", {31'd0, pend}, 32'd0);
    chk("rp_cnt",  cnt_cycle | cnt_stall | cnt_redir, 32'd0);
    cycle(0, 0, 0, 0);
    chk("rp_seq",  F_PC, 32'h3004);

`ifdef PC_CHECK_EN
    // Misaligned redirect raises fetch_exc, then vectors to the handler
    cycle(0, 0, 1, 32'h3002);
    chk("exc_pc",  F_PC, 32'h3002);
    chk("exc_on",  {31'd0, fetch_exc}, 32'd1);
    base_rdr = cnt_redir;
    cycle(0, 0, 1, 32'h3500);
    chk("exc_vec", F_PC, 32'h4180);
    chk("exc_off", {31'd0, fetch_exc}, 32'd0);
    chk("exc_rdr", cnt_redir, base_rdr);
`else
    // Low bits pass through, and PC+4 wraps modulo 2^32
    cycle(0, 0, 1, 32'h3003);
    chk("lowbits", F_PC, 32'h3003);
    cycle(0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_pc4", PC4, 32'h0);
    cycle(0, 0, 0, 0);
    chk("wrap_pc", F_PC, 32'h0);
    cycle(0, 0, 1, 32'h3000);
`endif

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      cycle(0, ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 30),
            32'h3000 + ($urandom_range(0, 4095) << 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
